// File: rtl/counter_pkg.sv
// Shared state encoding for the binary down-counter FSM.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

endpackage

// File: rtl/binary_down_counter.sv
// Loadable down-counter FSM with a registered one-cycle terminal-count pulse.
// Define DOWN_COUNTER_AUTO_RELOAD_EN for periodic reload at terminal count instead of one-shot.
module binary_down_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    state_t state;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reloadValue;
`endif

    // Priority is reset, then load, then the enabled decrement in RUN.
    // A count of 1 or less in RUN is the terminal edge, so 0 can never wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            tc    <= 1'b0;
            busy  <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reloadValue <= '0;
`endif
        end else if (load) begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reloadValue <= load_value;
`endif
            count <= load_value;
            if (load_value != '0) begin
                state <= RUN;
                tc    <= 1'b0;
                busy  <= 1'b1;
            end else begin
                state <= EXPIRED;
                tc    <= 1'b1;
                busy  <= 1'b0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (enable) begin
                        if (count > WIDTH'(1)) begin
                            count <= count - WIDTH'(1);
                            tc    <= 1'b0;
                        end else begin
                            tc <= 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                            count <= reloadValue;
`else
                            count <= '0;
                            state <= EXPIRED;
                            busy  <= 1'b0;
`endif
                        end
                    end else begin
                        tc <= 1'b0;
                    end
                end
                default: begin
                    tc <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_down_counter.sv
// Directed self-checking bench for binary_down_counter (WIDTH=4).
// Honors DOWN_COUNTER_AUTO_RELOAD_EN when the design is built with it.
module tb_binary_down_counter;

    localparam int WIDTH = 4;

    logic             clock;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;

    int total = 0;
    int bad   = 0;

    binary_down_counter #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .enable     (enable),
        .count      (count),
        .tc         (tc),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one set of inputs, take one rising edge, settle just after it.
    task automatic applyStimulus(input logic r, input logic l,
                                 input logic [WIDTH-1:0] lv, input logic e);
        reset      = r;
        load       = l;
        load_value = lv;
        enable     = e;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, wanted %0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [WIDTH-1:0] c,
                            input logic t, input logic b);
        checkOutput({tag, ".count"}, 32'(count), 32'(c));
        checkOutput({tag, ".tc"},    32'(tc),    32'(t));
        checkOutput({tag, ".busy"},  32'(busy),  32'(b));
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; load_value = '0; enable = 1'b0;

        // Reset held two cycles
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkAll("reset", 0, 0, 0);

        // Load 3 then enable continuously: 3,2,1,0 with tc only at 0
        applyStimulus(0, 1, 3, 0);
        checkAll("ld3", 3, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkAll("ld3.dec1", 2, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkAll("ld3.dec2", 1, 0, 1);
        applyStimulus(0, 0, 0, 1);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        checkAll("ld3.term", 3, 1, 1);
        applyStimulus(0, 0, 0, 1);
        checkAll("ld3.after", 2, 0, 1);
`else
        checkAll("ld3.term", 0, 1, 0);
        applyStimulus(0, 0, 0, 1);
        checkAll("ld3.expired1", 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkAll("ld3.expired2", 0, 0, 0);
`endif

        // Load 5, enable 1,0,0,1 -> 4,4,4,3
        applyStimulus(0, 1, 5, 0);
        checkAll("ld5", 5, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkAll("ld5.e1", 4, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkAll("ld5.e0a", 4, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkAll("ld5.e0b", 4, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkAll("ld5.e1b", 3, 0, 1);

        // Load 0 goes straight to EXPIRED with a tc pulse; enable ignored after
        applyStimulus(0, 1, 0, 0);
        checkAll("ld0", 0, 1, 0);
        applyStimulus(0, 0, 0, 1);
        checkAll("ld0.hold", 0, 0, 0);

        // Reset mid-count overrides a simultaneous load
        applyStimulus(0, 1, 3, 0);
        applyStimulus(0, 0, 0, 1);
        checkAll("mid.pre", 2, 0, 1);
        applyStimulus(1, 1, 7, 1);
        checkAll("mid.reset", 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkAll("idle.hold", 0, 0, 0);

        // Load on the terminal edge wins
        applyStimulus(0, 1, 2, 0);
        applyStimulus(0, 0, 0, 1);
        checkAll("term.pre", 1, 0, 1);
        applyStimulus(0, 1, 9, 1);
        checkAll("term.load9", 9, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkAll("term.dec", 8, 0, 1);

        // Full-scale load decrements without wrap
        applyStimulus(0, 1, 15, 0);
        checkAll("ld15", 15, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkAll("ld15.dec", 14, 0, 1);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        // Periodic reload of 2: 2,1,2,1,2,1 with tc on each reload edge
        applyStimulus(0, 1, 2, 0);
        checkAll("ar.ld", 2, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkAll("ar.e1", 1, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkAll("ar.e2", 2, 1, 1);
        applyStimulus(0, 0, 0, 1);
        checkAll("ar.e3", 1, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkAll("ar.e4", 2, 1, 1);
        applyStimulus(0, 0, 0, 1);
        checkAll("ar.e5", 1, 0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
